// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Front end for the game FSM. Each of the five raw push-buttons is passed
// through a two-flop synchroniser and a stability-counter debouncer to give a
// clean level. A small lockout FSM turns debounced rising edges into
// single-cycle press pulses. It allows at most one pulse per "all buttons
// released" interval, so one physical press advances the game only once.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   resetn     in   synchronous active-low reset
//   btn_raw    in   [N_BTN-1:0] asynchronous raw buttons, 1 = pressed
//                   bit order {right, left, bottom, top, center}
//   btn_level  out  [N_BTN-1:0] debounced level, registered
//   btn_pulse  out  [N_BTN-1:0] one-hot-or-zero press pulse, registered
//   any_pulse  out  OR of btn_pulse, registered
//   locked     out  1 while the lockout FSM is in HELD, registered
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_pulse,
    output logic             locked
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // The counter reaches this value after the input has differed from the
    // level for DEBOUNCE_CYCLES consecutive cycles.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Isolates the lowest set bit. This gives center the highest priority.
    function automatic logic [N_BTN-1:0] lowest_onehot(input logic [N_BTN-1:0] v);
        lowest_onehot = v & (~v + N_BTN'(1));
    endfunction

    logic [N_BTN-1:0] s1_r;
    logic [N_BTN-1:0] s2_r;
    logic [CNT_W-1:0] cnt_r     [N_BTN];
    logic [CNT_W-1:0] cnt_nxt_s [N_BTN];
    logic [N_BTN-1:0] level_nxt_s;
    logic [N_BTN-1:0] rise_s;
    state_t           state_r;

    // Next-state debounce per channel. Any mismatch that ends before the
    // terminal count clears the counter, so bounces restart the wait. The
    // counter clears at terminal count and never wraps.
    always_comb begin
        level_nxt_s = btn_level;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (s2_r[i] == btn_level[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == TERM_CNT) begin
                level_nxt_s[i] = s2_r[i];
                cnt_nxt_s[i]   = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // A rise is a level that is about to go 0->1 on this edge. This lets the
    // pulse coincide with the level change.
    always_comb begin
        rise_s = level_nxt_s & ~btn_level;
    end

    // Synchroniser, debounce counters and the debounced level register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_r      <= '0;
            s2_r      <= '0;
            btn_level <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            s1_r      <= btn_raw;
            s2_r      <= s1_r;
            btn_level <= level_nxt_s;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Lockout FSM. It emits one pulse and then waits until every debounced
    // level is released.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= IDLE;
            btn_pulse <= '0;
            any_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|rise_s) begin
                        state_r   <= HELD;
                        btn_pulse <= lowest_onehot(rise_s);
                        any_pulse <= 1'b1;
                        locked    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        btn_pulse <= '0;
                        any_pulse <= 1'b0;
                        locked    <= 1'b0;
                    end
                end
                HELD: begin
                    btn_pulse <= '0;
                    any_pulse <= 1'b0;
                    if (level_nxt_s == '0) begin
                        state_r <= IDLE;
                        locked  <= 1'b0;
                    end else begin
                        state_r <= HELD;
                        locked  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    btn_pulse <= '0;
                    any_pulse <= 1'b0;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES = 4. Outputs are
// sampled 1 ns after each rising edge. Edge numbering inside a scenario
// starts at 1 on the first edge that samples the new raw value. The
// debounced level and pulse therefore appear after edge 6 and not after
// edge 5.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int NB = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic          any_pulse;
    logic          locked;

    int n_vec = 0;
    int n_err = 0;

    btn_conditioner #(
        .N_BTN(NB),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .any_pulse(any_pulse),
        .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        btn_raw = 5'b00000;
        tick();
        tick();
        n_vec++;
        if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000 || any_pulse !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset: level=%b pulse=%b any=%b locked=%b, expected 00000 00000 0 0",
                     btn_level, btn_pulse, any_pulse, locked);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_clean_press();
        logic [NB-1:0] e_lvl, e_pls;
        logic          e_lck;
        btn_raw = 5'b00001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_lvl = (k >= 6) ? 5'b00001 : 5'b00000;
            e_pls = (k == 6) ? 5'b00001 : 5'b00000;
            e_lck = (k >= 6);
            n_vec++;
            if (btn_level !== e_lvl || btn_pulse !== e_pls || any_pulse !== (e_pls != 5'b00000) || locked !== e_lck) begin
                n_err++;
                $display("FAIL clean_press edge %0d: level=%b pulse=%b any=%b locked=%b, expected %b %b %b %b",
                         k, btn_level, btn_pulse, any_pulse, locked, e_lvl, e_pls, (e_pls != 5'b00000), e_lck);
            end
        end
    endtask

    // This follows test_clean_press, so center is still held and locked.
    task automatic test_release();
        logic [NB-1:0] e_lvl;
        logic          e_lck;
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_lvl = (k >= 6) ? 5'b00000 : 5'b00001;
            e_lck = (k < 6);
            n_vec++;
            if (btn_level !== e_lvl || btn_pulse !== 5'b00000 || any_pulse !== 1'b0 || locked !== e_lck) begin
                n_err++;
                $display("FAIL release edge %0d: level=%b pulse=%b any=%b locked=%b, expected %b 00000 0 %b",
                         k, btn_level, btn_pulse, any_pulse, locked, e_lvl, e_lck);
            end
        end
    endtask

    task automatic test_bounce();
        logic [NB-1:0] e_lvl, e_pls;
        int            n_pulse = 0;
        // Raw input is 1 for two edges, then 0 for two edges. Neither burst
        // lasts long enough to reach the terminal count.
        for (int k = 1; k <= 4; k++) begin
            btn_raw = (k <= 2) ? 5'b00010 : 5'b00000;
            tick();
            if (btn_pulse != 5'b00000) n_pulse++;
            n_vec++;
            if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000) begin
                n_err++;
                $display("FAIL bounce_early edge %0d: level=%b pulse=%b, expected 00000 00000",
                         k, btn_level, btn_pulse);
            end
        end
        btn_raw = 5'b00010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (btn_pulse != 5'b00000) n_pulse++;
            e_lvl = (k >= 6) ? 5'b00010 : 5'b00000;
            e_pls = (k == 6) ? 5'b00010 : 5'b00000;
            n_vec++;
            if (btn_level !== e_lvl || btn_pulse !== e_pls) begin
                n_err++;
                $display("FAIL bounce edge %0d: level=%b pulse=%b, expected %b %b",
                         k, btn_level, btn_pulse, e_lvl, e_pls);
            end
        end
        n_vec++;
        if (n_pulse != 1) begin
            n_err++;
            $display("FAIL bounce_count: pulses=%0d, expected 1", n_pulse);
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) tick();
        n_vec++;
        if (btn_level !== 5'b00000 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_release: level=%b locked=%b, expected 00000 0", btn_level, locked);
        end
    endtask

    task automatic test_simultaneous();
        logic [NB-1:0] e_lvl, e_pls;
        btn_raw = 5'b10100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_lvl = (k >= 6) ? 5'b10100 : 5'b00000;
            e_pls = (k == 6) ? 5'b00100 : 5'b00000;
            n_vec++;
            if (btn_level !== e_lvl || btn_pulse !== e_pls || locked !== (k >= 6)) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: level=%b pulse=%b locked=%b, expected %b %b %b",
                         k, btn_level, btn_pulse, locked, e_lvl, e_pls, (k >= 6));
            end
        end
        // With only bottom released, right is still held and the lock holds.
        btn_raw = 5'b10000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_lvl = (k >= 6) ? 5'b10000 : 5'b10100;
            n_vec++;
            if (btn_level !== e_lvl || btn_pulse !== 5'b00000 || locked !== 1'b1) begin
                n_err++;
                $display("FAIL simul_partial edge %0d: level=%b pulse=%b locked=%b, expected %b 00000 1",
                         k, btn_level, btn_pulse, locked, e_lvl);
            end
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (btn_pulse !== 5'b00000 || locked !== (k < 6)) begin
                n_err++;
                $display("FAIL simul_release edge %0d: pulse=%b locked=%b, expected 00000 %b",
                         k, btn_pulse, locked, (k < 6));
            end
        end
        // With all five pressed together, center wins.
        btn_raw = 5'b11111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_pls = (k == 6) ? 5'b00001 : 5'b00000;
            n_vec++;
            if (btn_pulse !== e_pls || any_pulse !== (k == 6)) begin
                n_err++;
                $display("FAIL all_press edge %0d: pulse=%b any=%b, expected %b %b",
                         k, btn_pulse, any_pulse, e_pls, (k == 6));
            end
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) tick();
    endtask

    task automatic test_held_second();
        logic [NB-1:0] e_lvl, e_pls;
        btn_raw = 5'b00010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_pls = (k == 6) ? 5'b00010 : 5'b00000;
            n_vec++;
            if (btn_pulse !== e_pls) begin
                n_err++;
                $display("FAIL held_top edge %0d: pulse=%b, expected %b", k, btn_pulse, e_pls);
            end
        end
        btn_raw = 5'b01010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_lvl = (k >= 6) ? 5'b01010 : 5'b00010;
            n_vec++;
            if (btn_level !== e_lvl || btn_pulse !== 5'b00000 || any_pulse !== 1'b0 || locked !== 1'b1) begin
                n_err++;
                $display("FAIL held_second edge %0d: level=%b pulse=%b any=%b locked=%b, expected %b 00000 0 1",
                         k, btn_level, btn_pulse, any_pulse, locked, e_lvl);
            end
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) tick();
        n_vec++;
        if (btn_level !== 5'b00000 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL held_release: level=%b locked=%b, expected 00000 0", btn_level, locked);
        end
        btn_raw = 5'b01000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_pls = (k == 6) ? 5'b01000 : 5'b00000;
            n_vec++;
            if (btn_pulse !== e_pls) begin
                n_err++;
                $display("FAIL repress_left edge %0d: pulse=%b, expected %b", k, btn_pulse, e_pls);
            end
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) tick();
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] e_pls;
        btn_raw = 5'b00010;
        for (int k = 1; k <= 8; k++) tick();
        n_vec++;
        if (locked !== 1'b1 || btn_level !== 5'b00010) begin
            n_err++;
            $display("FAIL pre_reset: level=%b locked=%b, expected 00010 1", btn_level, locked);
        end
        resetn = 1'b0;
        tick();
        n_vec++;
        if (btn_level !== 5'b00000 || btn_pulse !== 5'b00000 || any_pulse !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: level=%b pulse=%b any=%b locked=%b, expected 00000 00000 0 0",
                     btn_level, btn_pulse, any_pulse, locked);
        end
        // Top is still held, so the first edge out of reset is the sampling edge.
        resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e_pls = (k == 6) ? 5'b00010 : 5'b00000;
            n_vec++;
            if (btn_pulse !== e_pls || locked !== (k >= 6)) begin
                n_err++;
                $display("FAIL post_reset edge %0d: pulse=%b locked=%b, expected %b %b",
                         k, btn_pulse, locked, e_pls, (k >= 6));
            end
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) tick();
    endtask

    initial begin
        resetn  = 1'b0;
        btn_raw = 5'b00000;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_held_second();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
